// File: rtl/ir_queue_pkg.sv
// Shared definitions for the instruction register queue.
// Default sizes, a clog2 helper and instruction field positions.
package ir_queue_pkg;

   localparam int IR_WIDTH = 16;
   localparam int IR_DEPTH = 4;

   // Field positions used by downstream decode
   localparam int OP_MSB = 15;
   localparam int OP_LSB = 12;
   localparam int RD_MSB = 11;
   localparam int RD_LSB = 8;
   localparam int RS_MSB = 7;
   localparam int RS_LSB = 4;
   localparam int FN_MSB = 3;
   localparam int FN_LSB = 0;

   typedef struct packed {
      logic [OP_MSB-OP_LSB:0] op;
      logic [RD_MSB-RD_LSB:0] rd;
      logic [RS_MSB-RS_LSB:0] rs;
      logic [FN_MSB-FN_LSB:0] fn;
   } ir_fields_t;

   function automatic int ir_clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic ir_fields_t ir_split(input logic [15:0] w);
      return ir_fields_t'(w);
   endfunction

endpackage

// File: rtl/ir_queue_mem.sv
// Queue storage: DEPTH x WIDTH array, one write port, one read port.
// No reset; contents are only meaningful under the queue pointers.
module ir_queue_mem
   import ir_queue_pkg::*;
#(
   parameter int WIDTH = IR_WIDTH,
   parameter int DEPTH = IR_DEPTH,
   parameter int AW    = ir_clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ir_queue.sv
// Instruction register with a small in-order prefetch queue.
// Head word is held in a register so Q never follows D combinationally.
module ir_queue
   import ir_queue_pkg::*;
#(
   parameter int WIDTH = IR_WIDTH,
   parameter int DEPTH = IR_DEPTH,
   parameter int CW    = ir_clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld,
   input  logic [WIDTH-1:0] D,
   input  logic             adv,
   input  logic             flush,
   output logic [WIDTH-1:0] Q,
   output logic             valid,
   output logic             full,
   output logic [CW-1:0]    count,
   output logic             ovf
);

   localparam int AW = ir_clog2(DEPTH);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] rdata;
   logic             ovf_r;
   logic             full_w;
   logic             valid_w;
   logic             wr;
   logic             rd;
   logic             drop;

   assign full_w  = (cnt == CW'(DEPTH));
   assign valid_w = (cnt != '0);

   always_comb begin
      wr      = ld & (~full_w | adv);
      rd      = adv & valid_w;
      drop    = ld & full_w & ~adv;
      rd_nxt  = rd ? rd_ptr + AW'(1) : rd_ptr;
      cnt_nxt = cnt;
      unique case ({wr, rd})
         2'b10:   cnt_nxt = cnt + CW'(1);
         2'b01:   cnt_nxt = cnt - CW'(1);
         default: cnt_nxt = cnt;
      endcase
      // New head is the word being written only when it lands at rd_nxt
      q_nxt = '0;
      if (!flush && cnt_nxt != '0) begin
         if (wr && wr_ptr == rd_nxt)
            q_nxt = D;
         else
            q_nxt = rdata;
      end
   end

   ir_queue_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr & ~flush),
      .waddr (wr_ptr),
      .wdata (D),
      .raddr (rd_nxt),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         q_r    <= '0;
         ovf_r  <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         q_r    <= '0;
         ovf_r  <= 1'b0;
      end else begin
         if (wr)
            wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_nxt;
         cnt    <= cnt_nxt;
         q_r    <= q_nxt;
         if (drop)
            ovf_r <= 1'b1;
      end
   end

   assign Q     = q_r;
   assign valid = valid_w;
   assign full  = full_w;
   assign count = cnt;
   assign ovf   = ovf_r;

endmodule

// File: tb/tb_ir_queue.sv
// Self-checking bench for ir_queue with a queue scoreboard.
// Accepted loads are pushed; consumed heads are popped and compared.
module tb_ir_queue;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic             clk;
   logic             reset;
   logic             ld;
   logic [WIDTH-1:0] D;
   logic             adv;
   logic             flush;
   logic [WIDTH-1:0] Q;
   logic             valid;
   logic             full;
   logic [CW-1:0]    count;
   logic             ovf;

   int errors;
   int checks;

   logic [WIDTH-1:0] sb[$];
   logic             movf;

   ir_queue #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .ld    (ld),
      .D     (D),
      .adv   (adv),
      .flush (flush),
      .Q     (Q),
      .valid (valid),
      .full  (full),
      .count (count),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [WIDTH-1:0] eq;
      eq = (sb.size() != 0) ? sb[0] : '0;
      check({tag, ".Q"}, 32'(Q), 32'(eq));
      check({tag, ".count"}, 32'(count), 32'(sb.size()));
      check({tag, ".valid"}, 32'(valid), 32'(sb.size() != 0));
      check({tag, ".full"}, 32'(full), 32'(sb.size() == DEPTH));
      check({tag, ".ovf"}, 32'(ovf), 32'(movf));
   endtask

   // Drive at negedge, model the edge from pre-edge state, sample #1 after
   task automatic step(input logic l, input logic [WIDTH-1:0] d,
                       input logic a, input logic f, input string tag);
      bit mfull;
      bit mwr;
      bit mrd;
      ld    = l;
      D     = d;
      adv   = a;
      flush = f;
      mfull = (sb.size() == DEPTH);
      mwr   = l && (!mfull || a);
      mrd   = a && (sb.size() != 0);
      @(posedge clk);
      if (f) begin
         sb.delete();
         movf = 1'b0;
      end else begin
         if (l && mfull && !a)
            movf = 1'b1;
         if (mrd)
            void'(sb.pop_front());
         if (mwr)
            sb.push_back(d);
      end
      #1;
      check_model(tag);
      @(negedge clk);
      ld    = 1'b0;
      adv   = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] w;
      errors = 0;
      checks = 0;
      movf   = 1'b0;
      reset  = 1'b0;
      ld     = 1'b0;
      D      = '0;
      adv    = 1'b0;
      flush  = 1'b0;
      repeat (2) @(negedge clk);
      check_model("rst");
      reset = 1'b1;

      // Reset mid-stream
      step(1, 16'h0A01, 0, 0, "pre1");
      step(1, 16'h0A02, 0, 0, "pre2");
      step(1, 16'h0A03, 0, 0, "pre3");
      #2;
      reset = 1'b0;
      #1;
      sb.delete();
      movf = 1'b0;
      check("async.Q", 32'(Q), 32'h0);
      check("async.count", 32'(count), 32'h0);
      check("async.valid", 32'(valid), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // In-order fill and drain
      step(1, 16'h1111, 0, 0, "fill");
      step(1, 16'h2222, 0, 0, "fill");
      step(1, 16'h3333, 0, 0, "fill");
      step(1, 16'h4444, 0, 0, "fill");
      check("fill.full", 32'(full), 32'h1);
      check("fill.count", 32'(count), 32'h4);
      check("fill.Q", 32'(Q), 32'h1111);
      step(0, 16'h0, 1, 0, "drain");
      check("drain1.Q", 32'(Q), 32'h2222);
      step(0, 16'h0, 1, 0, "drain");
      check("drain2.Q", 32'(Q), 32'h3333);
      step(0, 16'h0, 1, 0, "drain");
      check("drain3.Q", 32'(Q), 32'h4444);
      step(0, 16'h0, 1, 0, "drain");
      check("drain4.Q", 32'(Q), 32'h0);
      check("drain4.valid", 32'(valid), 32'h0);

      // Overflow then simultaneous load/advance on full
      step(1, 16'h1111, 0, 0, "refill");
      step(1, 16'h2222, 0, 0, "refill");
      step(1, 16'h3333, 0, 0, "refill");
      step(1, 16'h4444, 0, 0, "refill");
      step(1, 16'hBEEF, 0, 0, "ovf");
      check("ovf.ovf", 32'(ovf), 32'h1);
      check("ovf.count", 32'(count), 32'h4);
      step(1, 16'h5555, 1, 0, "simul");
      check("simul.count", 32'(count), 32'h4);
      check("simul.Q", 32'(Q), 32'h2222);
      step(0, 16'h0, 1, 0, "post");
      step(0, 16'h0, 1, 0, "post");
      step(0, 16'h0, 1, 0, "post");
      check("simul5.Q", 32'(Q), 32'h5555);
      step(0, 16'h0, 1, 0, "post");

      // Empty edge cases
      step(0, 16'h0, 1, 0, "empty_adv");
      check("empty.count", 32'(count), 32'h0);
      check("empty.Q", 32'(Q), 32'h0);
      step(1, 16'hA5A5, 1, 0, "empty_ldadv");
      check("empty_ld.count", 32'(count), 32'h1);
      check("empty_ld.Q", 32'(Q), 32'hA5A5);
      check("ovf.held", 32'(ovf), 32'h1);
      step(0, 16'h0, 0, 1, "flush0");
      check("flush0.ovf", 32'(ovf), 32'h0);

      // Fill/drain across repeated pointer wraps
      for (int i = 0; i < 10; i++) begin
         w = 16'(16'h3000 + 2 * i);
         step(1, w, 0, 0, "wrap");
         step(1, w + 16'h1, 0, 0, "wrap");
         step(0, 16'h0, 1, 0, "wrap");
         step(0, 16'h0, 1, 0, "wrap");
      end
      step(1, 16'h7001, 0, 0, "pref");
      step(1, 16'h7002, 0, 0, "pref");
      step(1, 16'hDEAD, 0, 1, "flush_ld");
      check("flush.count", 32'(count), 32'h0);
      check("flush.ovf", 32'(ovf), 32'h0);
      check("flush.Q", 32'(Q), 32'h0);
      step(0, 16'h0, 1, 0, "idle");
      step(1, 16'h7003, 0, 0, "after");

      // Randomised traffic against the scoreboard
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 1)), 16'($urandom),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 31) == 0), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register with a small prefetch queue, the next generation of the CPU execution unit's single-entry instruction register. Instructions fetched from memory are loaded in order; the oldest one is presented on Q for decode until the control unit advances past it. This decouples fetch from decode and allows up to DEPTH instructions to be prefetched. A synchronous flush supports branches.

## Interface
- WIDTH, 16, instruction width in bits.
- DEPTH, 4, queue entries; power of two, at least 2.
- CW, derived as clog2(DEPTH+1), width of count.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low (asserted at 0); no other clock or reset exists.
- ld  input  1  load D into the tail of the queue this cycle.
- D  input  WIDTH  instruction word from memory.
- adv  input  1  consume the instruction at the head (on Q).
- flush  input  1  synchronous clear of all queued instructions.
- Q  output  WIDTH  head instruction; 0 when empty.
- valid  output  1  Q holds a real instruction (count != 0).
- full  output  1  count == DEPTH.
- count  output  CW  number of instructions held.
- ovf  output  1  sticky overflow flag.

## Operation
- Reset (reset = 0, any time, asynchronous): Q = 0, valid = 0, full = 0, count = 0, ovf = 0, pointers = 0. Storage contents are don't-care. Reset asserted mid-operation discards all entries immediately.
- Each edge evaluates the effective write and read from the pre-edge state:
  - wr = ld and (not full or adv).
  - rd = adv and valid.
- Priority:
  - flush overrides ld and adv. On flush, count = 0 and the pointers return to 0. Q = 0 and valid = 0 on the next cycle. ovf clears.
- Writes and reads:
  - A write stores D at wr_ptr, then wr_ptr increments modulo DEPTH.
  - A read increments rd_ptr modulo DEPTH.
  - count changes by +1 on wr only, by -1 on rd only, and is unchanged when both or neither occur.
- Full queue with ld and adv together: the write is accepted, the head retires, and count stays at DEPTH.
- Full queue with ld and no adv: the word is dropped, the queue is unchanged, and ovf is set to 1 and held until flush or reset.
- Empty queue with adv: ignored, with no count underflow. If ld also occurs in that cycle, the write is accepted.
- Q always shows the entry at the post-edge rd_ptr when count is not 0, and 0 otherwise. Q is driven from a register and is never combinational from D.
- There are no other states. Behaviour is fully described by count and the pointers; no FSM beyond this is required.

## Timing
- Load to Q latency when the queue is empty: 1 cycle. ld at edge k makes Q = D and valid = 1 after edge k.
- Advance to next Q: 1 cycle. Q updates at the same edge that consumes the head.
- full, count, and ovf are registered and update at the same edge as the queue state.
- flush has 1-cycle effect: Q = 0 and valid = 0 after the flushing edge. A same-cycle ld is discarded.
- The pointers wrap naturally because DEPTH is a power of two. The design must be correct across repeated wraps.

## Structure
- Shared header ir_defs.vh holds:
  - default WIDTH = 16 and DEPTH = 4;
  - the clog2 function macro;
  - the instruction-field bit positions (opcode, register fields) for downstream decode.
- Natural sub-module: ir_queue_mem, a DEPTH x WIDTH storage array with one write port and one read port, no reset.
  - Pointers, count, ovf, and the registered Q live in ir_queue.

## Test plan
- Reset mid-stream: load 3 words, then pull reset to 0 between edges. Required: Q = 0, count = 0, and valid = 0 immediately, before the next edge.
- In-order fill and drain (defaults): ld 16'h1111, 16'h2222, 16'h3333, 16'h4444.
  - After the fill: full = 1, count = 4, Q = 16'h1111.
  - Four adv pulses present Q = 2222, 3333, 4444, then Q = 0 with valid = 0.
- Overflow: with the queue full, ld 16'hBEEF without adv. Required: ovf = 1, count stays at 4, and BEEF never appears on Q. ovf stays 1 until flush.
- Simultaneous on full: with the queue full, ld 16'h5555 with adv. Required: count = 4, Q = 16'h2222, and 5555 is presented after three further adv.
- Empty edge case: with count = 0, adv alone leaves count = 0 and Q = 0. ld 16'hA5A5 with adv gives count = 1 and Q = A5A5.
- Flush and wrap:
  - Run 10 fill/drain cycles with 20 words. Order must be preserved across the pointer wraps.
  - Then flush together with ld. Required: count = 0, ovf = 0, and the discarded word never appears.
